// File: rtl/paddle_if.sv
`default_nettype none
// ============================================================================
// Module      : paddle_if
// Description : Bundles the board-button, ball-state and paddle-position
//               signals exchanged between the board/ball engine and
//               paddle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface paddle_if;
    logic       refresh_tick;
    logic       btn1_up;
    logic       btn1_down;
    logic       btn2_up;
    logic       btn2_down;
    logic       ai_enable;
    logic [9:0] ball_y;
    logic [9:0] ball_dx;
    logic       game_over;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;

    // Board / ball-engine side: drives buttons and ball state, consumes paddles
    modport master (
        output refresh_tick, btn1_up, btn1_down, btn2_up, btn2_down,
        output ai_enable, ball_y, ball_dx, game_over,
        input  paddle1_y, paddle2_y
    );

    // Paddle controller side
    modport slave (
        input  refresh_tick, btn1_up, btn1_down, btn2_up, btn2_down,
        input  ai_enable, ball_y, ball_dx, game_over,
        output paddle1_y, paddle2_y
    );
endinterface
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : paddle_ctrl
// Description : Produces both paddle positions once per refresh tick.
//               Player 1 follows debounced buttons; player 2 follows either
//               debounced buttons or a lagged ball-tracking opponent.
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
    parameter int TOP_MARGIN   = 25,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_H     = 72,
    parameter int PADDLE_SPEED = 4,
    parameter int DEBOUNCE_N   = 16,
    parameter int AI_LAG       = 4,
    parameter int AI_DEADBAND  = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    paddle_if.slave   bus
);

    localparam int               c_Y_MAX_I  = SCREEN_H - TOP_MARGIN - PADDLE_H;
    localparam logic [9:0]       c_Y_MAX    = 10'(c_Y_MAX_I);
    localparam logic [9:0]       c_Y_RST    = 10'(c_Y_MAX_I / 2);
    // Ball row that puts the paddle centre on the reset position
    localparam logic [9:0]       c_DL_RST   = 10'(c_Y_MAX_I / 2 + TOP_MARGIN + PADDLE_H / 2);
    localparam logic [10:0]      c_SPEED    = 11'(PADDLE_SPEED);
    localparam logic signed [11:0] c_SPEED_S  = 12'(PADDLE_SPEED);
    localparam logic signed [11:0] c_DEADBAND = 12'(AI_DEADBAND);
    localparam logic signed [11:0] c_TGT_OFS  = 12'(TOP_MARGIN + PADDLE_H / 2);
    localparam int               c_CNT_W    = $clog2(DEBOUNCE_N + 1);

    // ------------------------------------------------------------------
    // Button conditioning: bit order {btn2_down, btn2_up, btn1_down, btn1_up}
    // ------------------------------------------------------------------
    logic [3:0] w_btn_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_db;

    assign w_btn_raw = {bus.btn2_down, bus.btn2_up, bus.btn1_down, bus.btn1_up};

    // Two-stage synchronizer for the raw asynchronous buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_db;

        // Accept a new level only after it has persisted DEBOUNCE_N cycles
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_sync2[gi] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_W'(DEBOUNCE_N - 1)) begin
                r_db  <= r_sync2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_db[gi] = r_db;
    end

    // ------------------------------------------------------------------
    // Button-driven movement with saturation at both playfield edges
    // ------------------------------------------------------------------
    function automatic logic [9:0] f_move(input logic [9:0] y,
                                          input logic       up,
                                          input logic       dn);
        logic [10:0] y11;
        y11 = {1'b0, y};
        if (up && !dn) begin
            f_move = (y11 >= c_SPEED) ? 10'(y11 - c_SPEED) : 10'd0;
        end else if (dn && !up) begin
            f_move = ((y11 + c_SPEED) <= {1'b0, c_Y_MAX}) ? 10'(y11 + c_SPEED) : c_Y_MAX;
        end else begin
            f_move = y;
        end
    endfunction

    // ------------------------------------------------------------------
    // AI: ball_y delay line and tracking step
    // ------------------------------------------------------------------
    logic [9:0]        r_dl [AI_LAG];
    logic [9:0]        r_p1;
    logic [9:0]        r_p2;
    logic [9:0]        w_dl_old;
    logic signed [11:0] w_tgt_raw;
    logic signed [11:0] w_tgt;
    logic signed [11:0] w_diff;
    logic signed [11:0] w_abs;
    logic signed [11:0] w_step;
    logic [9:0]        w_ai_next;
    logic              w_unused_dx;

    assign w_dl_old    = r_dl[AI_LAG-1];
    assign w_unused_dx = ^bus.ball_dx[8:0];

    // Ball history shifts on every tick, even while frozen or in button mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < AI_LAG; i++) begin
                r_dl[i] <= c_DL_RST;
            end
        end else if (bus.refresh_tick) begin
            r_dl[0] <= bus.ball_y;
            for (int i = 1; i < AI_LAG; i++) begin
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    // Target selection and bounded step toward it; ball moving away recentres
    always_comb begin
        w_tgt_raw = $signed({2'b00, w_dl_old}) - c_TGT_OFS;
        w_tgt     = w_tgt_raw;
        if (bus.ball_dx[9]) begin
            w_tgt = $signed({2'b00, c_Y_RST});
        end else if (w_tgt_raw < 12'sd0) begin
            w_tgt = 12'sd0;
        end else if (w_tgt_raw > $signed({2'b00, c_Y_MAX})) begin
            w_tgt = $signed({2'b00, c_Y_MAX});
        end
        w_diff = w_tgt - $signed({2'b00, r_p2});
        w_abs  = (w_diff < 12'sd0) ? -w_diff : w_diff;
        w_step = (w_abs > c_SPEED_S) ? c_SPEED_S : w_abs;
        if (w_abs <= c_DEADBAND) begin
            w_ai_next = r_p2;
        end else if (w_diff < 12'sd0) begin
            w_ai_next = r_p2 - w_step[9:0];
        end else begin
            w_ai_next = r_p2 + w_step[9:0];
        end
    end

    // Paddle position registers, advanced on unfrozen ticks only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1 <= c_Y_RST;
            r_p2 <= c_Y_RST;
        end else if (bus.refresh_tick && !bus.game_over) begin
            r_p1 <= f_move(r_p1, w_db[0], w_db[1]);
            r_p2 <= bus.ai_enable ? w_ai_next : f_move(r_p2, w_db[2], w_db[3]);
        end
    end

    assign bus.paddle1_y = r_p1;
    assign bus.paddle2_y = r_p2;

endmodule
`default_nettype wire
